// File: rtl/axi_lite_regbank_slave.sv
// AXI4-Lite responder for a bank of NUM_REGS 32-bit registers.
// One outstanding write and one outstanding read. AW and W may arrive in any
// order. Out-of-range accesses return SLVERR.
module axi_lite_regbank_slave #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        RESP_OKAY  = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    logic [31:0]       regs [NUM_REGS];

    logic              aw_held;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_held;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;

    logic [IDX_W-1:0]  aw_idx;
    logic [IDX_W-1:0]  ar_idx;
    logic              aw_in_range;
    logic              ar_in_range;
    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [31:0]       merged;

    // Readies depend only on internal state; forced low while in reset
    assign s_awready = rstn && !aw_held && !s_bvalid;
    assign s_wready  = rstn && !w_held  && !s_bvalid;
    assign s_arready = rstn && !s_rvalid;

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid  && s_wready;
    assign ar_hs  = s_arvalid && s_arready;
    assign commit = aw_held && w_held;

    assign aw_idx      = aw_addr[IDX_W+1:2];
    assign ar_idx      = s_araddr[IDX_W+1:2];
    assign aw_in_range = aw_addr < ADDR_LIMIT;
    assign ar_in_range = s_araddr < ADDR_LIMIT;

    // Byte-merge the held write data into the current register value
    always_comb begin
        merged = regs[aw_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_strb[b]) begin
                merged[8*b +: 8] = w_data[8*b +: 8];
            end
        end
    end

    // Register bank: updated only on an in-range commit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (commit && aw_in_range) begin
            regs[aw_idx] <= merged;
        end
    end

    // Write address holding register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held <= 1'b0;
            aw_addr <= '0;
        end else if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= s_awaddr;
        end else if (commit) begin
            aw_held <= 1'b0;
        end
    end

    // Write data holding register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_held <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (w_hs) begin
            w_held <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
        end else if (commit) begin
            w_held <= 1'b0;
        end
    end

    // Write response channel: raised on commit, held until bready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (commit) begin
            s_bvalid <= 1'b1;
            s_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_bvalid && s_bready) begin
            s_bvalid <= 1'b0;
        end
    end

    // Read channel: capture on AR handshake, hold until rready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= ar_in_range ? regs[ar_idx] : '0;
            s_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Directed bench for axi_lite_regbank_slave: a vector table of single
// writes/reads plus hand-written multi-cycle sequences.
module tb_axi_lite_regbank_slave;

    logic        clk;
    logic        rstn;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    int total;
    int bad;

    axi_lite_regbank_slave #(
        .ADDR_W   (32),
        .NUM_REGS (16),
        .RESET_VAL(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue AW and W together, wait for B; called #1 after a rising edge
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_now, w_now;
        int n;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = s_awvalid && s_awready;
            w_now  = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (aw_now) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; s_wvalid  = 1'b0; end
            n++;
        end
        if (n >= 20) check("wr_addr_data_timeout", 32'd0, 32'd1);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("wr_resp_timeout", 32'd0, 32'd1);
        resp = s_bresp;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    // Issue AR, wait for R; called #1 after a rising edge
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        logic ar_now;
        int n;
        s_araddr = addr; s_arvalid = 1'b1;
        n = 0;
        ar_now = 1'b0;
        while (!ar_now && n < 20) begin
            ar_now = s_arready;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("rd_addr_timeout", 32'd0, 32'd1);
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("rd_data_timeout", 32'd0, 32'd1);
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        total = 0;
        bad   = 0;
        rstn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

        // 0x14=reg5 written in sequence 1; 0x40 is just beyond the bank
        vecs[0]  = '{1'b0, 32'h14,       32'h0,        4'h0, 2'b00, 32'hDDDD_DDDD};
        vecs[1]  = '{1'b1, 32'h04,       32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[2]  = '{1'b1, 32'h04,       32'h0000_0000, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h04,       32'h0,        4'h0, 2'b00, 32'hFF00_FF00};
        vecs[4]  = '{1'b1, 32'h40,       32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h40,       32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 32'h00,       32'h0,        4'h0, 2'b00, 32'h0};
        vecs[7]  = '{1'b1, 32'h3C,       32'hAABB_CCDD, 4'hF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'h3E,       32'h0,        4'h0, 2'b00, 32'hAABB_CCDD};
        vecs[9]  = '{1'b1, 32'h3C,       32'h1122_3344, 4'h0, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h3C,       32'h0,        4'h0, 2'b00, 32'hAABB_CCDD};
        vecs[11] = '{1'b1, 32'h3C,       32'h1122_3344, 4'h8, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h3C,       32'h0,        4'h0, 2'b00, 32'h11BB_CCDD};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0, 2'b10, 32'h0};

        // Reset: readies low while asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_readies_low", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_readies_high", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
        check("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
        check("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);

        // Sequence 1: AW and W together, bready held high, latency check
        s_awaddr = 32'h14; s_wdata = 32'hDDDD_DDDD; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("t1_bvalid_after_hs", {31'd0, s_bvalid}, 32'd0);
        check("t1_ready_held", {30'd0, s_awready, s_wready}, 32'd0);
        @(posedge clk); #1;
        check("t1_bvalid", {31'd0, s_bvalid}, 32'd1);
        check("t1_bresp", {30'd0, s_bresp}, 32'd0);
        @(posedge clk); #1;
        check("t1_bvalid_clear", {31'd0, s_bvalid}, 32'd0);
        s_bready = 1'b0;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
            end else begin
                do_read(vecs[i].addr, data, resp);
                check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].resp});
                check($sformatf("vec%0d_rdata", i), data, vecs[i].rdata);
            end
        end

        // Sequence 2: W three cycles before AW
        s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_wait%0d_aw_w_b", k), {29'd0, s_awready, s_wready, s_bvalid}, 32'd4);
            @(posedge clk); #1;
        end
        s_awaddr = 32'h08; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        check("t2_after_aw", {29'd0, s_awready, s_wready, s_bvalid}, 32'd0);
        @(posedge clk); #1;
        check("t2_bvalid_up", {29'd0, s_awready, s_wready, s_bvalid}, 32'd1);
        check("t2_bresp", {30'd0, s_bresp}, 32'd0);
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        check("t2_after_b", {29'd0, s_awready, s_wready, s_bvalid}, 32'd6);
        @(posedge clk); #1;
        check("t2_single_b", {31'd0, s_bvalid}, 32'd0);
        do_read(32'h08, data, resp);
        check("t2_rdata", data, 32'h1234_5678);

        // Sequence 5: stalled B and R channels
        s_awaddr = 32'h30; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clk); #1;
        s_araddr = 32'h30; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_b_stall%0d", k),
                  {27'd0, s_bvalid, s_bresp, s_awready, s_wready}, 32'h10);
            check($sformatf("t5_r_stall%0d", k), {28'd0, s_rvalid, s_rresp, s_arready}, 32'h8);
            check($sformatf("t5_rdata%0d", k), s_rdata, 32'hCAFE_F00D);
            @(posedge clk); #1;
        end
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        check("t5_released", {27'd0, s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, 32'h7);

        // Read capture on the same edge as a write commit to that register
        s_awaddr = 32'h14; s_wdata = 32'h55AA_55AA; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h14; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        check("sim_valids", {30'd0, s_bvalid, s_rvalid}, 32'd3);
        check("sim_old_rdata", s_rdata, 32'hDDDD_DDDD);
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        do_read(32'h14, data, resp);
        check("sim_new_rdata", data, 32'h55AA_55AA);

        // Sequence 6: reset with AW held and no W
        s_awaddr = 32'h10; s_awvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        check("t6_aw_held", {30'd0, s_awready, s_wready}, 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_in_reset_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("t6_after_reset", {28'd0, s_awready, s_wready, s_arready, s_bvalid}, 32'hE);
        s_wdata = 32'h9999_9999; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6_no_b%0d", k), {31'd0, s_bvalid}, 32'd0);
            @(posedge clk); #1;
        end
        for (int r = 0; r < 16; r++) begin
            do_read(32'(r * 4), data, resp);
            check($sformatf("t6_reg%0d", r), data, 32'h0000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
